// File: rtl/pll_reconfig_ctrl.sv
// Runtime reconfiguration sequencer for NumPlls clock generators: gate, settle, program, wait lock, ungate, respond.
// Optional IDLE-time lock-loss monitor is compiled in when PLL_RECONFIG_LOCK_MONITOR_EN is defined.
module pll_reconfig_ctrl #(
    parameter int NumPlls      = 3,
    parameter int MultWidth    = 16,
    parameter int DivWidth     = 4,
    parameter int SettleCycles = 4,
    parameter int LockTimeout  = 1024,
    parameter int IdxWidth     = (NumPlls > 1) ? $clog2(NumPlls) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdxWidth-1:0]  req_pll_i,
    input  logic [MultWidth-1:0] req_mult_i,
    input  logic [DivWidth-1:0]  req_div_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_err_o,
    output logic [NumPlls-1:0]   pll_cfg_we_o,
    output logic [MultWidth-1:0] pll_mult_o,
    output logic [DivWidth-1:0]  pll_div_o,
    input  logic [NumPlls-1:0]   pll_lock_i,
    output logic [NumPlls-1:0]   clk_gate_en_o,
    output logic                 busy_o,
    output logic [NumPlls-1:0]   lock_lost_o,
    input  logic [NumPlls-1:0]   lock_lost_clr_i
);

    localparam int CntMax   = (LockTimeout > SettleCycles) ? LockTimeout : SettleCycles;
    localparam int CntWidth = $clog2(CntMax + 1);
    localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] LockLast   = CntWidth'(LockTimeout - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_SETTLE,
        ST_PROGRAM,
        ST_WAIT_LOCK,
        ST_UNGATE,
        ST_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [MultWidth-1:0] mult_q, mult_d;
    logic [DivWidth-1:0]  div_q, div_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 lock_prev_q, lock_prev_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;
    logic [NumPlls-1:0]   cfg_we_q, cfg_we_d;
    logic [MultWidth-1:0] pll_mult_q, pll_mult_d;
    logic [DivWidth-1:0]  pll_div_q, pll_div_d;
    logic [NumPlls-1:0]   gate_q, gate_d;

    logic [NumPlls-1:0]   sel;
    logic [NumPlls-1:0]   req_sel;
    logic                 req_bad;
    logic                 lock_sel;

    // One-hot decodes of the latched and incoming PLL index; out-of-range indices decode to zero.
    generate
        for (genvar gi = 0; gi < NumPlls; gi++) begin : g_sel
            assign sel[gi]     = (idx_q == IdxWidth'(gi));
            assign req_sel[gi] = (req_pll_i == IdxWidth'(gi));
        end
    endgenerate

    assign req_bad  = (32'(req_pll_i) >= NumPlls) || (req_div_i == '0);
    assign lock_sel = |(pll_lock_i & sel);

`ifdef PLL_RECONFIG_LOCK_MONITOR_EN
    logic [NumPlls-1:0] lost_q, lost_d;
    logic [NumPlls-1:0] mon_prev_q;
    logic [NumPlls-1:0] lock_fall;

    assign lock_fall = mon_prev_q & ~pll_lock_i & gate_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lost_q     <= '0;
            mon_prev_q <= '0;
        end else begin
            lost_q     <= lost_d;
            mon_prev_q <= pll_lock_i;
        end
    end

    assign lock_lost_o = lost_q;
`else
    logic lock_clr_unused;
    assign lock_clr_unused = |lock_lost_clr_i;
    assign lock_lost_o     = '0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mult_d      = mult_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        lock_prev_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        cfg_we_d    = '0;
        pll_mult_d  = pll_mult_q;
        pll_div_d   = pll_div_q;
        gate_d      = gate_q;
`ifdef PLL_RECONFIG_LOCK_MONITOR_EN
        lost_d      = lost_q & ~lock_lost_clr_i;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    idx_d  = req_pll_i;
                    mult_d = req_mult_i;
                    div_d  = req_div_i;
                    if (req_bad) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        // Gate is dropped on the accept edge so it is already off during GATE.
                        state_d = ST_GATE;
                        gate_d  = gate_q & ~req_sel;
                    end
                end
            end
            ST_GATE: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SettleLast) begin
                    cnt_d      = '0;
                    state_d    = ST_PROGRAM;
                    cfg_we_d   = sel;
                    pll_mult_d = mult_q;
                    pll_div_d  = div_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PROGRAM: begin
                cnt_d   = '0;
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                lock_prev_d = lock_sel;
                // Two consecutive lock samples take priority over an expiring timeout.
                if (lock_sel && lock_prev_q) begin
                    cnt_d   = '0;
                    state_d = ST_UNGATE;
                end else if (cnt_q == LockLast) begin
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UNGATE: begin
                gate_d      = gate_q | sel;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
`ifdef PLL_RECONFIG_LOCK_MONITOR_EN
                lost_d      = lost_d & ~sel;
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PLL_RECONFIG_LOCK_MONITOR_EN
        if (state_q == ST_IDLE) begin
            lost_d = lost_d | lock_fall;
            gate_d = gate_d & ~lock_fall;
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            mult_q      <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            lock_prev_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_we_q    <= '0;
            pll_mult_q  <= '0;
            pll_div_q   <= '0;
            gate_q      <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mult_q      <= mult_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            lock_prev_q <= lock_prev_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            cfg_we_q    <= cfg_we_d;
            pll_mult_q  <= pll_mult_d;
            pll_div_q   <= pll_div_d;
            gate_q      <= gate_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign busy_o        = busy_q;
    assign pll_cfg_we_o  = cfg_we_q;
    assign pll_mult_o    = pll_mult_q;
    assign pll_div_o     = pll_div_q;
    assign clk_gate_en_o = gate_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed, table-driven bench for pll_reconfig_ctrl (default parameters, 3 PLLs).
// Builds with or without PLL_RECONFIG_LOCK_MONITOR_EN; the lock-monitor sequence follows the macro.
module tb_pll_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_pll = '0;
    logic [15:0] req_mult = '0;
    logic [3:0]  req_div = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_err;
    logic [2:0]  cfg_we;
    logic [15:0] pll_mult;
    logic [3:0]  pll_div;
    logic [2:0]  pll_lock = 3'b111;
    logic [2:0]  gate;
    logic        busy;
    logic [2:0]  lost;
    logic [2:0]  lost_clr = '0;

    always #5 clk = ~clk;

    pll_reconfig_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_pll_i       (req_pll),
        .req_mult_i      (req_mult),
        .req_div_i       (req_div),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_err_o       (rsp_err),
        .pll_cfg_we_o    (cfg_we),
        .pll_mult_o      (pll_mult),
        .pll_div_o       (pll_div),
        .pll_lock_i      (pll_lock),
        .clk_gate_en_o   (gate),
        .busy_o          (busy),
        .lock_lost_o     (lost),
        .lock_lost_clr_i (lost_clr)
    );

    typedef struct {
        logic [1:0]  pll;
        logic [15:0] mult;
        logic [3:0]  div;
        logic [2:0]  lock;
        logic        err;
        int          lat;
        logic [2:0]  we;
        int          we_cyc;
        logic [2:0]  gate_mid;
        logic [2:0]  gate_end;
        logic [15:0] pmult;
        logic [3:0]  pdiv;
    } vec_t;

    vec_t vecs[6];

    int n_pass  = 0;
    int n_total = 0;
    int n;
    int we_cnt;
    int we_cyc;
    int bad;
    logic [2:0] we_or;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {17'b0, req_ready, busy, rsp_valid, rsp_err, gate, cfg_we, lost},
              {17'b0, 4'b1000, 3'b111, 3'b000, 3'b000});
        check({tag, "_cfg"}, {12'b0, pll_mult, pll_div}, 32'h0);
    endtask

    task automatic do_reset(input logic [2:0] lock);
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pll   = '0;
        req_mult  = '0;
        req_div   = '0;
        rsp_ready = 1'b1;
        lost_clr  = '0;
        pll_lock  = lock;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pll    mult      div    lock    err   lat   we      wecyc gmid    gend    pmult     pdiv
        vecs[0] = '{2'd1, 16'h0040, 4'd2,  3'b111, 1'b0, 10,   3'b010, 6,    3'b101, 3'b111, 16'h0040, 4'd2};
        vecs[1] = '{2'd0, 16'h1234, 4'd15, 3'b111, 1'b0, 10,   3'b001, 6,    3'b110, 3'b111, 16'h1234, 4'd15};
        vecs[2] = '{2'd2, 16'hFFFF, 4'd1,  3'b100, 1'b0, 10,   3'b100, 6,    3'b011, 3'b111, 16'hFFFF, 4'd1};
        vecs[3] = '{2'd3, 16'h0ABC, 4'd5,  3'b111, 1'b1, 1,    3'b000, 0,    3'b111, 3'b111, 16'h0000, 4'd0};
        vecs[4] = '{2'd1, 16'h0ABC, 4'd0,  3'b111, 1'b1, 1,    3'b000, 0,    3'b111, 3'b111, 16'h0000, 4'd0};
        vecs[5] = '{2'd0, 16'h0077, 4'd3,  3'b110, 1'b1, 1031, 3'b001, 6,    3'b110, 3'b110, 16'h0077, 4'd3};

        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].lock);
            check_reset_vals($sformatf("v%0d_reset", v));
            req_valid = 1'b1;
            req_pll   = vecs[v].pll;
            req_mult  = vecs[v].mult;
            req_div   = vecs[v].div;
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("v%0d_busy_c1", v), {31'b0, busy}, 32'd1);
            n = 1; we_or = '0; we_cnt = 0; we_cyc = 0; bad = 0;
            while (n <= 2000) begin
                if (cfg_we != 3'b000) begin
                    we_or  = we_or | cfg_we;
                    we_cnt = we_cnt + 1;
                    we_cyc = n;
                end
                if (rsp_valid) break;
                if (gate !== vecs[v].gate_mid) bad++;
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_latency", v), n, vecs[v].lat);
            check($sformatf("v%0d_err", v), {31'b0, rsp_err}, {31'b0, vecs[v].err});
            check($sformatf("v%0d_gate_hold", v), bad, 0);
            check($sformatf("v%0d_gate_end", v), {29'b0, gate}, {29'b0, vecs[v].gate_end});
            check($sformatf("v%0d_we_mask", v), {29'b0, we_or}, {29'b0, vecs[v].we});
            check($sformatf("v%0d_we_count", v), we_cnt, (vecs[v].we != 3'b000) ? 1 : 0);
            check($sformatf("v%0d_we_cycle", v), we_cyc, vecs[v].we_cyc);
            check($sformatf("v%0d_cfg", v), {12'b0, pll_mult, pll_div},
                  {12'b0, vecs[v].pmult, vecs[v].pdiv});
            @(negedge clk);
            check($sformatf("v%0d_idle_after", v), {29'b0, rsp_valid, req_ready, busy}, 32'b010);
            $display("vector %0d: pll=%0d div=%0d latency=%0d err=%0b", v, vecs[v].pll, vecs[v].div, n, vecs[v].err);
        end

        // Backpressure with a second request waiting behind the held response.
        do_reset(3'b111);
        req_valid = 1'b1; req_pll = 2'd2; req_mult = 16'h0005; req_div = 4'd3;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_pll = 2'd0; req_mult = 16'h0009; req_div = 4'd1;
        n = 1; bad = 0;
        while (n <= 2000 && !rsp_valid) begin
            if (req_ready) bad++;
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, 10);
        check("bp_ready_low_busy", bad, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!(rsp_valid === 1'b1 && rsp_err === 1'b0 && req_ready === 1'b0 && pll_mult === 16'h0005)) bad++;
            if (k == 19) rsp_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_rsp_hold", bad, 0);
        check("bp_idle_after_hs", {30'b0, rsp_valid, req_ready}, 32'b01);
        @(negedge clk);
        check("bp_second_accept", {27'b0, busy, req_ready, gate}, {27'b0, 2'b10, 3'b110});
        req_valid = 1'b0;
        n = 1;
        while (n <= 2000 && !rsp_valid) begin
            @(negedge clk);
            n++;
        end
        check("bp_second_latency", n, 10);
        check("bp_second_rsp", {11'b0, rsp_err, pll_mult, pll_div}, {11'b0, 1'b0, 16'h0009, 4'd1});
        $display("backpressure: second request response latency=%0d", n);

        // Asynchronous reset while the sequence is in SETTLE.
        do_reset(3'b111);
        req_valid = 1'b1; req_pll = 2'd1; req_mult = 16'h0022; req_div = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rm_gate_settle", {29'b0, gate}, {29'b0, 3'b101});
        rst = 1'b1;
        #1;
        check_reset_vals("rm_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rm_after");
        $display("reset mid-sequence: gate=%b busy=%b", gate, busy);

        // Lock loss while idle.
        do_reset(3'b111);
        @(negedge clk);
        @(negedge clk);
        pll_lock = 3'b011;
        @(negedge clk);
`ifdef PLL_RECONFIG_LOCK_MONITOR_EN
        check("mon_set", {26'b0, lost, gate}, {26'b0, 3'b100, 3'b011});
        lost_clr = 3'b100;
        @(negedge clk);
        lost_clr = 3'b000;
        check("mon_clr", {29'b0, lost}, 32'b0);
        check("mon_gate_stays", {29'b0, gate}, {29'b0, 3'b011});
`else
        check("nomon_lost", {26'b0, lost, gate}, {26'b0, 3'b000, 3'b111});
        lost_clr = 3'b100;
        @(negedge clk);
        lost_clr = 3'b000;
        check("nomon_after_clr", {26'b0, lost, gate}, {26'b0, 3'b000, 3'b111});
`endif
        $display("lock drop on pll 2: lost=%b gate=%b", lost, gate);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
